// File: rtl/random_candidate_picker.sv
// random_candidate_picker: uniform LFSR pick of one set candidate bit with bounded-retry lowest-bit fallback; define RAND_PICK_FREE_RUN_EN for a free-running LFSR
module random_candidate_picker #(
  parameter int WIDTH = 9,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int MAX_TRIES = 32,
  localparam int IDXW = $clog2(WIDTH),
  localparam int DW = $clog2(WIDTH + 1)
) (
  input  logic             clk_in,
  input  logic             reset_in,
  input  logic             req_in,
  input  logic [WIDTH-1:0] cand_mask_in,
  output logic             busy_out,
  output logic             valid_out,
  output logic             empty_out,
  output logic [WIDTH-1:0] pick_mask_out,
  output logic [DW-1:0]    pick_digit_out
);
  localparam int N = 1 << IDXW;
  localparam int TW = $clog2(MAX_TRIES + 1);
  localparam logic [15:0] SEED = (LFSR_SEED == 16'h0) ? 16'hACE1 : LFSR_SEED;
  typedef enum logic [1:0] {IDLE, DRAW, FALLBACK} state_t;
  state_t state, state_n;
  logic [15:0] lfsr, lfsr_n, lfsr_step;
  logic [WIDTH-1:0] cand_q, cand_n, mask_n;
  logic [N-1:0] cand_ext;
  logic [TW-1:0] tries, tries_n;
  logic [IDXW-1:0] idx, low_idx;
  logic [DW-1:0] digit_n;
  logic valid_n, empty_n, hit;
  assign lfsr_step = (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 16'h0);
  assign idx = lfsr[IDXW-1:0];
  assign cand_ext = N'(cand_q);
  assign hit = cand_ext[idx];
  assign busy_out = state != IDLE;
  always_comb begin
    low_idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--)
      if (cand_q[i]) low_idx = IDXW'(i);
  end
  always_comb begin
    state_n = state;
    cand_n = cand_q;
    tries_n = tries;
    valid_n = 1'b0;
    empty_n = 1'b0;
    mask_n = pick_mask_out;
    digit_n = pick_digit_out;
`ifdef RAND_PICK_FREE_RUN_EN
    lfsr_n = lfsr_step;
`else
    lfsr_n = lfsr;
`endif
    if (state == IDLE && req_in) begin
      cand_n = cand_mask_in;
      tries_n = '0;
      if (cand_mask_in == '0) begin
        valid_n = 1'b1;
        empty_n = 1'b1;
        mask_n = '0;
        digit_n = '0;
      end else begin
        state_n = DRAW;
      end
    end else if (state == DRAW) begin
      lfsr_n = lfsr_step;
      if (hit) begin
        valid_n = 1'b1;
        mask_n = WIDTH'(1) << idx;
        digit_n = DW'(idx) + DW'(1);
        state_n = IDLE;
      end else begin
        tries_n = tries + TW'(1);
        state_n = (tries == TW'(MAX_TRIES - 1)) ? FALLBACK : DRAW;
      end
    end else if (state == FALLBACK) begin
      valid_n = 1'b1;
      mask_n = WIDTH'(1) << low_idx;
      digit_n = DW'(low_idx) + DW'(1);
      state_n = IDLE;
    end
  end
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state <= IDLE;
      lfsr <= SEED;
      cand_q <= '0;
      tries <= '0;
      valid_out <= 1'b0;
      empty_out <= 1'b0;
      pick_mask_out <= '0;
      pick_digit_out <= '0;
    end else begin
      state <= state_n;
      lfsr <= lfsr_n;
      cand_q <= cand_n;
      tries <= tries_n;
      valid_out <= valid_n;
      empty_out <= empty_n;
      pick_mask_out <= mask_n;
      pick_digit_out <= digit_n;
    end
  end
endmodule

// File: tb/tb_random_candidate_picker.sv
// tb_random_candidate_picker: randomized requests checked against a transaction-level picker model
module tb_random_candidate_picker;
  localparam logic [15:0] SEED = 16'hACE1;
  localparam logic [15:0] SEED1 = 16'h1230;
  localparam int MAXT = 32;
  logic clk, rst, req, req1;
  logic [8:0] cand, cand1, pmask, pmask1;
  logic busy, valid, empty, busy1, valid1, empty1;
  logic [3:0] pdigit, pdigit1;
  logic [15:0] mlfsr;
  int total = 0;
  int bad = 0;
  int last_digit;
  random_candidate_picker #(.WIDTH(9), .LFSR_SEED(SEED), .MAX_TRIES(MAXT)) dut (
    .clk_in(clk), .reset_in(rst), .req_in(req), .cand_mask_in(cand),
    .busy_out(busy), .valid_out(valid), .empty_out(empty),
    .pick_mask_out(pmask), .pick_digit_out(pdigit)
  );
  random_candidate_picker #(.WIDTH(9), .LFSR_SEED(SEED1), .MAX_TRIES(1)) dut1 (
    .clk_in(clk), .reset_in(rst), .req_in(req1), .cand_mask_in(cand1),
    .busy_out(busy1), .valid_out(valid1), .empty_out(empty1),
    .pick_mask_out(pmask1), .pick_digit_out(pdigit1)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0);
  endfunction
  function automatic int model_pick(input logic [8:0] m, output int lat);
    int k;
    lat = 1;
    if (m == 9'd0) return 0;
    for (int t = 0; t < MAXT; t++) begin
      k = int'(mlfsr[3:0]);
      mlfsr = lfsr_next(mlfsr);
      if (k < 9 && m[k]) begin
        lat = t + 2;
        return k + 1;
      end
    end
    lat = MAXT + 2;
    for (int i = 0; i < 9; i++)
      if (m[i]) return i + 1;
    return 0;
  endfunction
  task automatic run_req(input logic [8:0] m, input string tag);
    int lat, exp_lat, exp_d;
    logic [8:0] exp_m;
    exp_d = model_pick(m, exp_lat);
    exp_m = (exp_d == 0) ? 9'd0 : 9'd1 << (exp_d - 1);
    req = 1'b1;
    cand = m;
    @(negedge clk);
    req = 1'b0;
    cand = 9'($urandom);
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      if (valid) begin
        lat = c;
        break;
      end
      if (c == 1) check({tag, "_busy1"}, busy, m != 9'd0);
      @(negedge clk);
    end
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_digit"}, pdigit, exp_d);
    check({tag, "_mask"}, pmask, exp_m);
    check({tag, "_empty"}, empty, m == 9'd0);
    check({tag, "_busy_done"}, busy, 0);
    last_digit = int'(pdigit);
  endtask
  initial begin
    int n1, lat1;
    logic [8:0] m1, m;
    logic [3:0] d1;
    logic e1;
    int cnt [1:9];
    rst = 1'b1;
    req = 1'b0;
    req1 = 1'b0;
    cand = '0;
    cand1 = '0;
    mlfsr = SEED;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_valid", valid, 0);
    check("rst_empty", empty, 0);
    check("rst_busy", busy, 0);
    check("rst_mask", pmask, 0);
    check("rst_digit", pdigit, 0);
    check("rst1_busy", busy1, 0);
    req1 = 1'b1;
    cand1 = 9'h180;
    @(negedge clk);
    n1 = 0;
    lat1 = 0;
    m1 = '0;
    d1 = '0;
    e1 = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      req1 = (c <= 2);
      cand1 = 9'h1FF;
      if (c == 1) check("fb_busy1", busy1, 1);
      if (valid1) begin
        n1++;
        if (lat1 == 0) begin
          lat1 = c;
          m1 = pmask1;
          d1 = pdigit1;
          e1 = empty1;
        end
      end
      @(negedge clk);
    end
    req1 = 1'b0;
    check("fb_valid_count", n1, 1);
    check("fb_lat", lat1, 3);
    check("fb_digit", d1, 8);
    check("fb_mask", m1, 9'h080);
    check("fb_empty", e1, 0);
    run_req(9'h1FF, "first_full");
    check("first_full_seed_digit", last_digit, 2);
    run_req(9'h010, "single5");
    check("single5_digit5", last_digit, 5);
    run_req(9'h000, "empty");
    for (int i = 0; i < 300; i++) begin
      m = 9'($urandom);
      if ($urandom_range(0, 9) == 0) m = 9'd0;
      run_req(m, "rand");
    end
    req = 1'b1;
    cand = 9'h010;
    @(negedge clk);
    req = 1'b0;
    check("abort_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_valid", valid, 0);
    check("abort_busy_clr", busy, 0);
    check("abort_mask", pmask, 0);
    check("abort_digit", pdigit, 0);
    check("abort_empty", empty, 0);
    @(negedge clk);
    check("abort_no_late_valid", valid, 0);
    mlfsr = SEED;
    run_req(9'h1FF, "post_rst");
    for (int d = 1; d <= 9; d++) cnt[d] = 0;
    for (int i = 0; i < 9000; i++) begin
      run_req(9'h1FF, "dist");
      if (last_digit >= 1 && last_digit <= 9) cnt[last_digit]++;
    end
    for (int d = 1; d <= 9; d++) check("dist_range", (cnt[d] >= 850 && cnt[d] <= 1150), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
